// File: rtl/ad7226_emu_pkg.sv
// Shared constants and FSM encoding for the AD7226-style serial ADC responder.
package ad7226_emu_pkg;

  localparam int LEAD_Z_DEF    = 4;
  localparam int DATA_W_DEF    = 12;
  localparam int FRAME_LEN_DEF = LEAD_Z_DEF + DATA_W_DEF;

  // Saturation ceiling of the 8-bit abort counter.
  localparam logic [7:0] ABORT_MAX = 8'hFF;

  typedef enum logic [1:0] {
    ST_WAIT_HI = 2'd0,
    ST_IDLE    = 2'd1,
    ST_SHIFT   = 2'd2,
    ST_TAIL    = 2'd3
  } state_t;

endpackage

// File: rtl/ad7226_emu_sync_edge.sv
// N-stage synchronizer for an asynchronous pin plus a one-flop edge detector.
// All flops reset to 1, matching the idle level of cs_n and sclk.
// Pin-to-event latency is STAGES+1 clock edges once the FSM registers the event.
module ad7226_emu_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the pin through the synchronizer chain and remember the last synced level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign sync_o = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/ad7226_emu.sv
// AD7226-style ADC slave emulator: a cs_n/sclk driven serial responder that
// sends LEAD_Z zeros followed by DATA_W sample bits MSB-first per frame.
// Samples come from a one-deep valid/ready holding register or an internal ramp.
//
// Handshake: smp_data is transferred on a clk_sys edge where smp_valid && smp_ready;
// smp_ready is high exactly when the holding register is empty and pat_en is low,
// and smp_valid/smp_data must stay stable until that transfer happens.
module ad7226_emu
  import ad7226_emu_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int LEAD_Z      = LEAD_Z_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              sclk,
  output logic              sdata,
  output logic              sdata_oe,
  input  logic [DATA_W-1:0] smp_data,
  input  logic              smp_valid,
  output logic              smp_ready,
  input  logic              pat_en,
  output logic              frame_done,
  output logic              underrun,
  input  logic              underrun_clr,
  output logic [7:0]        abort_cnt,
  output logic [1:0]        dbg_state_o
);

  localparam int FRAME_LEN = LEAD_Z + DATA_W;
  localparam int CNT_W     = $clog2(FRAME_LEN);
  localparam int FLUSH_W   = $clog2(SYNC_STAGES + 2);

  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(FRAME_LEN - 1);
  // Synchronizer flops reset to 1, so cs_n held low through reset only shows
  // up after the chain has flushed; WAIT_HI waits this long before trusting it.
  localparam logic [FLUSH_W-1:0] FLUSH_N = FLUSH_W'(SYNC_STAGES + 1);

  // Conditioned pin events
  logic cs_sync, cs_rise, cs_fall;
  logic sclk_sync, sclk_rise, sclk_fall;

  ad7226_emu_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .clk_i   (clk_sys),
    .rst_i   (rst),
    .async_i (cs_n),
    .sync_o  (cs_sync),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  ad7226_emu_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk_i   (clk_sys),
    .rst_i   (rst),
    .async_i (sclk),
    .sync_o  (sclk_sync),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  // State
  state_t                state_q,     state_d;
  logic [FRAME_LEN-1:0]  shreg_q,     shreg_d;
  logic [CNT_W-1:0]      bit_cnt_q,   bit_cnt_d;
  logic                  sdata_q,     sdata_d;
  logic                  oe_q,        oe_d;
  logic [DATA_W-1:0]     hold_q,      hold_d;
  logic                  hold_full_q, hold_full_d;
  logic [DATA_W-1:0]     last_q,      last_d;
  logic [DATA_W-1:0]     ramp_q,      ramp_d;
  logic                  underrun_q,  underrun_d;
  logic [7:0]            abort_q,     abort_d;
  logic                  fdone_q,     fdone_d;
  logic [FLUSH_W-1:0]    flush_q,     flush_d;

  logic                  accept;
  logic [DATA_W-1:0]     word;

  assign smp_ready = ~hold_full_q & ~pat_en;
  assign accept    = smp_valid & smp_ready;

  // State register and datapath flops.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q     <= ST_WAIT_HI;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      sdata_q     <= 1'b0;
      oe_q        <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      last_q      <= '0;
      ramp_q      <= '0;
      underrun_q  <= 1'b0;
      abort_q     <= '0;
      fdone_q     <= 1'b0;
      flush_q     <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      sdata_q     <= sdata_d;
      oe_q        <= oe_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      last_q      <= last_d;
      ramp_q      <= ramp_d;
      underrun_q  <= underrun_d;
      abort_q     <= abort_d;
      fdone_q     <= fdone_d;
      flush_q     <= flush_d;
    end
  end

  // Next-state logic: frame sequencing, sample selection and status flags.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    sdata_d     = sdata_q;
    oe_d        = oe_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    last_d      = last_q;
    ramp_d      = ramp_q;
    underrun_d  = underrun_q & ~underrun_clr;
    abort_d     = abort_q;
    fdone_d     = 1'b0;
    flush_d     = flush_q;
    word        = last_q;

    // Accept cannot coincide with a hold load: the load needs hold_full=1,
    // which holds smp_ready low in that same cycle.
    if (accept) begin
      hold_d      = smp_data;
      hold_full_d = 1'b1;
    end

    unique case (state_q)
      ST_WAIT_HI: begin
        sdata_d = 1'b0;
        oe_d    = 1'b0;
        if (flush_q != FLUSH_N) begin
          flush_d = flush_q + 1'b1;
        end else if (cs_sync) begin
          state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (cs_fall) begin
          if (pat_en) begin
            word   = ramp_q;
            ramp_d = ramp_q + 1'b1;
          end else if (hold_full_q) begin
            word        = hold_q;
            hold_full_d = 1'b0;
            last_d      = hold_q;
          end else begin
            word       = last_q;
            underrun_d = 1'b1;
          end
          shreg_d   = {{LEAD_Z{1'b0}}, word};
          bit_cnt_d = CNT_MAX;
          sdata_d   = shreg_d[FRAME_LEN-1];
          oe_d      = 1'b1;
          state_d   = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        // An early cs_rise aborts the frame and takes priority over sclk.
        if (cs_rise) begin
          state_d = ST_IDLE;
          oe_d    = 1'b0;
          sdata_d = 1'b0;
          if (abort_q != ABORT_MAX) abort_d = abort_q + 1'b1;
        end else if (sclk_fall) begin
          if (bit_cnt_q != '0) begin
            shreg_d   = shreg_q << 1;
            bit_cnt_d = bit_cnt_q - 1'b1;
            sdata_d   = shreg_q[FRAME_LEN-2];
          end else begin
            fdone_d = 1'b1;
            sdata_d = 1'b0;
            state_d = ST_TAIL;
          end
        end
      end

      ST_TAIL: begin
        sdata_d = 1'b0;
        if (cs_rise) begin
          state_d = ST_IDLE;
          oe_d    = 1'b0;
        end
      end

      default: state_d = ST_WAIT_HI;
    endcase
  end

  assign sdata       = sdata_q;
  assign sdata_oe    = oe_q;
  assign frame_done  = fdone_q;
  assign underrun    = underrun_q;
  assign abort_cnt   = abort_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ad7226_emu.sv
// Directed bench for ad7226_emu: a behavioural SPI-style master captures frames
// and every result is compared against hand-computed values.
module tb_ad7226_emu;

  localparam int HALF = 25;  // sclk half period in clk_sys cycles (1 MHz at 50 MHz)

  // Clock / reset
  logic        clk_sys = 1'b0;
  logic        rst;
  logic        cs_n;
  logic        sclk;
  logic        sdata;
  logic        sdata_oe;
  logic [11:0] smp_data;
  logic        smp_valid;
  logic        smp_ready;
  logic        pat_en;
  logic        frame_done;
  logic        underrun;
  logic        underrun_clr;
  logic [7:0]  abort_cnt;
  logic [1:0]  dbg_state;

  always #10 clk_sys = ~clk_sys;

  ad7226_emu dut (
    .clk_sys      (clk_sys),
    .rst          (rst),
    .cs_n         (cs_n),
    .sclk         (sclk),
    .sdata        (sdata),
    .sdata_oe     (sdata_oe),
    .smp_data     (smp_data),
    .smp_valid    (smp_valid),
    .smp_ready    (smp_ready),
    .pat_en       (pat_en),
    .frame_done   (frame_done),
    .underrun     (underrun),
    .underrun_clr (underrun_clr),
    .abort_cnt    (abort_cnt),
    .dbg_state_o  (dbg_state)
  );

  // Scoreboard counters
  int checks   = 0;
  int failures = 0;
  int fd_cnt   = 0;

  always @(negedge clk_sys) if (frame_done) fd_cnt++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic push(input logic [11:0] v);
    int g;
    g = 0;
    while (!smp_ready && g < 100) begin
      wait_cyc(1);
      g++;
    end
    check_val("push_ready", {31'd0, smp_ready}, 32'd1);
    smp_data  = v;
    smp_valid = 1'b1;
    wait_cyc(1);
    smp_valid = 1'b0;
  endtask

  // Master: data is captured late in each sclk-high phase, just before the
  // falling edge that advances the responder to the next bit.
  task automatic frame(input int nbits, output logic [15:0] cap, output int lat);
    cap  = '0;
    cs_n = 1'b0;
    for (int k = 0; k < nbits; k++) begin
      wait_cyc(HALF);
      cap  = {cap[14:0], sdata};
      sclk = 1'b0;
      wait_cyc(HALF);
      sclk = 1'b1;
    end
    wait_cyc(HALF);
    cs_n = 1'b1;
    lat  = 0;
    while (sdata_oe && lat < 20) begin
      wait_cyc(1);
      lat++;
    end
    wait_cyc(HALF);
  endtask

  logic [15:0] cap;
  int          lat;
  int          fd0;

  initial begin
    rst = 1'b1; cs_n = 1'b1; sclk = 1'b1; smp_data = '0; smp_valid = 1'b0;
    pat_en = 1'b0; underrun_clr = 1'b0;
    wait_cyc(5);
    rst = 1'b0;

    // Reset state
    check_val("rst_sdata",    {31'd0, sdata},      32'd0);
    check_val("rst_oe",       {31'd0, sdata_oe},   32'd0);
    check_val("rst_ready",    {31'd0, smp_ready},  32'd1);
    check_val("rst_fdone",    {31'd0, frame_done}, 32'd0);
    check_val("rst_underrun", {31'd0, underrun},   32'd0);
    check_val("rst_abort",    {24'd0, abort_cnt},  32'd0);
    check_val("rst_state",    {30'd0, dbg_state},  32'd0);
    wait_cyc(10);
    check_val("idle_state",   {30'd0, dbg_state},  32'd1);

    // Streamed sample 0xABC
    push(12'hABC);
    wait_cyc(1);
    check_val("held_ready", {31'd0, smp_ready}, 32'd0);
    fd0 = fd_cnt;
    frame(16, cap, lat);
    check_val("abc_cap",      {16'd0, cap},       32'h0ABC);
    check_val("abc_fdone",    fd_cnt - fd0,       32'd1);
    check_val("abc_ready",    {31'd0, smp_ready}, 32'd1);
    check_val("abc_oe_off",   {31'd0, sdata_oe},  32'd0);
    check_val("abc_underrun", {31'd0, underrun},  32'd0);

    // Ramp pattern, three frames
    pat_en = 1'b1;
    wait_cyc(1);
    check_val("pat_ready", {31'd0, smp_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      frame(16, cap, lat);
      check_val("pat_cap",   {16'd0, cap},       i);
      check_val("pat_ready", {31'd0, smp_ready}, 32'd0);
    end
    pat_en = 1'b0;
    wait_cyc(2);

    // One sample, two frames: second frame repeats it and flags underrun
    push(12'h123);
    frame(16, cap, lat);
    check_val("s123_cap1",  {16'd0, cap},      32'h0123);
    check_val("s123_undr1", {31'd0, underrun}, 32'd0);
    frame(16, cap, lat);
    check_val("s123_cap2",  {16'd0, cap},      32'h0123);
    check_val("s123_undr2", {31'd0, underrun}, 32'd1);
    underrun_clr = 1'b1;
    wait_cyc(1);
    underrun_clr = 1'b0;
    wait_cyc(1);
    check_val("undr_clr",   {31'd0, underrun}, 32'd0);

    // Abort after 7 sclk falls
    push(12'h456);
    fd0 = fd_cnt;
    frame(7, cap, lat);
    check_val("abort_cap",   {16'd0, cap},       32'h0002);
    check_val("abort_lat",   {31'd0, lat <= 4},  32'd1);
    check_val("abort_cnt",   {24'd0, abort_cnt}, 32'd1);
    check_val("abort_fdone", fd_cnt - fd0,       32'd0);
    push(12'h789);
    fd0 = fd_cnt;
    frame(16, cap, lat);
    check_val("after_abort_cap",   {16'd0, cap},      32'h0789);
    check_val("after_abort_fdone", fd_cnt - fd0,      32'd1);
    check_val("after_abort_undr",  {31'd0, underrun}, 32'd0);

    // Reset mid-SHIFT with cs_n held low
    push(12'h5A5);
    cs_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wait_cyc(HALF);
      sclk = 1'b0;
      wait_cyc(HALF);
      sclk = 1'b1;
    end
    check_val("mid_state", {30'd0, dbg_state}, 32'd2);
    check_val("mid_oe",    {31'd0, sdata_oe},  32'd1);
    rst = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    check_val("mrst_oe",    {31'd0, sdata_oe},  32'd0);
    check_val("mrst_ready", {31'd0, smp_ready}, 32'd1);
    wait_cyc(100);
    check_val("mrst_hold_oe",    {31'd0, sdata_oe},  32'd0);
    check_val("mrst_hold_state", {30'd0, dbg_state}, 32'd0);
    fd0  = fd_cnt;
    cs_n = 1'b1;
    wait_cyc(10);
    check_val("mrst_idle", {30'd0, dbg_state}, 32'd1);
    push(12'h321);
    frame(16, cap, lat);
    check_val("mrst_cap",   {16'd0, cap},       32'h0321);
    check_val("mrst_fdone", fd_cnt - fd0,       32'd1);
    check_val("mrst_abort", {24'd0, abort_cnt}, 32'd0);

    // Advance the ramp 0 -> 4095 with short aborted frames, then check wrap
    pat_en = 1'b1;
    for (int i = 0; i < 4095; i++) begin
      cs_n = 1'b0;
      wait_cyc(4);
      cs_n = 1'b1;
      wait_cyc(4);
    end
    wait_cyc(10);
    check_val("abort_sat", {24'd0, abort_cnt}, 32'd255);
    frame(16, cap, lat);
    check_val("ramp_fff", {16'd0, cap}, 32'h0FFF);
    frame(16, cap, lat);
    check_val("ramp_wrap", {16'd0, cap}, 32'h0000);
    pat_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
